// File: rtl/axis_pkg.sv
// Shared constants for the AXI-Stream byte packer.
// Lane widths, word geometry and keep-mask encodings.
package axis_pkg;

   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = WORD_BYTES * BYTE_W;
   localparam int LEN_W      = 16;

   localparam logic [WORD_BYTES-1:0] KEEP_1 = 4'h1;
   localparam logic [WORD_BYTES-1:0] KEEP_2 = 4'h3;
   localparam logic [WORD_BYTES-1:0] KEEP_3 = 4'h7;
   localparam logic [WORD_BYTES-1:0] KEEP_4 = 4'hF;

endpackage

// File: rtl/axis_byte_packer.sv
// 8-bit to 32-bit AXI-Stream packer with keep/last, packet
// length reporting and a delivered-packet counter.
module axis_byte_packer
   import axis_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BYTE_W-1:0]     s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   output logic [WORD_W-1:0]     m_data,
   output logic [WORD_BYTES-1:0] m_keep,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [LEN_W-1:0]      m_len,
   output logic [LEN_W-1:0]      pkt_count
);

   logic [3*BYTE_W-1:0]     acc_q, acc_d;
   logic [1:0]              idx_q, idx_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        len_inc;
   logic [WORD_W-1:0]       data_q, data_d;
   logic [WORD_BYTES-1:0]   keep_q, keep_d;
   logic                    last_q, last_d;
   logic                    valid_q, valid_d;
   logic [LEN_W-1:0]        mlen_q, mlen_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic                    accept;
   logic                    commit;

   // Output register is the only buffer, so input readiness
   // follows downstream readiness combinationally.
   assign s_ready = rst && (!valid_q || m_ready);
   assign accept  = s_valid && s_ready;
   assign commit  = accept && ((idx_q == 2'd3) || s_last);
   assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;

   // Next-state for accumulator, output word and counters.
   always_comb begin
      acc_d   = acc_q;
      idx_d   = idx_q;
      len_d   = len_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;
      mlen_d  = mlen_q;
      cnt_d   = cnt_q;

      if (valid_q && m_ready) begin
         valid_d = 1'b0;
         if (last_q) cnt_d = cnt_q + 1'b1;
      end

      if (accept) begin
         len_d = len_inc;
         if (commit) begin
            case (idx_q)
               2'd0: begin
                  data_d = {PAD_BYTE, PAD_BYTE, PAD_BYTE, s_data};
                  keep_d = KEEP_1;
               end
               2'd1: begin
                  data_d = {PAD_BYTE, PAD_BYTE, s_data, acc_q[7:0]};
                  keep_d = KEEP_2;
               end
               2'd2: begin
                  data_d = {PAD_BYTE, s_data, acc_q[15:0]};
                  keep_d = KEEP_3;
               end
               default: begin
                  data_d = {s_data, acc_q};
                  keep_d = KEEP_4;
               end
            endcase
            last_d  = s_last;
            valid_d = 1'b1;
            idx_d   = 2'd0;
            if (s_last) begin
               mlen_d = len_inc;
               len_d  = '0;
            end
         end else begin
            case (idx_q)
               2'd0:    acc_d[7:0]   = s_data;
               2'd1:    acc_d[15:8]  = s_data;
               default: acc_d[23:16] = s_data;
            endcase
            idx_d = idx_q + 2'd1;
         end
      end
   end

   // State registers; reset discards any partial packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         mlen_q  <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         mlen_q  <= mlen_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_data    = data_q;
   assign m_keep    = keep_q;
   assign m_last    = last_q;
   assign m_valid   = valid_q;
   assign m_len     = mlen_q;
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed self-checking bench for axis_byte_packer.
// Two instances: zero padding and 0xFF padding.
module tb_axis_byte_packer;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [15:0] len;
   } wrd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [7:0]  s_data0 = '0;
   logic        s_valid0 = 1'b0;
   logic        s_last0 = 1'b0;
   logic        s_ready0;
   logic [31:0] m_data0;
   logic [3:0]  m_keep0;
   logic        m_valid0;
   logic        m_ready0;
   logic        m_last0;
   logic [15:0] m_len0;
   logic [15:0] pkt0;

   logic [7:0]  s_data1 = '0;
   logic        s_valid1 = 1'b0;
   logic        s_last1 = 1'b0;
   logic        s_ready1;
   logic [31:0] m_data1;
   logic [3:0]  m_keep1;
   logic        m_valid1;
   logic        m_last1;
   logic [15:0] m_len1;
   logic [15:0] pkt1;

   logic        rdy_man = 1'b1;
   logic        rdy_rnd = 1'b1;
   logic        rnd_mode = 1'b0;

   int checks = 0;
   int errors = 0;

   wrd_t q0[$];
   wrd_t q1[$];
   wrd_t gq[$];

   assign m_ready0 = rnd_mode ? rdy_rnd : rdy_man;

   always #5 clk = ~clk;

   axis_byte_packer #(.PAD_BYTE(8'h00)) u0 (
      .clk(clk), .rst(rst),
      .s_data(s_data0), .s_valid(s_valid0),
      .s_ready(s_ready0), .s_last(s_last0),
      .m_data(m_data0), .m_keep(m_keep0),
      .m_valid(m_valid0), .m_ready(m_ready0),
      .m_last(m_last0), .m_len(m_len0),
      .pkt_count(pkt0)
   );

   axis_byte_packer #(.PAD_BYTE(8'hFF)) u1 (
      .clk(clk), .rst(rst),
      .s_data(s_data1), .s_valid(s_valid1),
      .s_ready(s_ready1), .s_last(s_last1),
      .m_data(m_data1), .m_keep(m_keep1),
      .m_valid(m_valid1), .m_ready(1'b1),
      .m_last(m_last1), .m_len(m_len1),
      .pkt_count(pkt1)
   );

   always @(posedge clk) begin
      #1;
      rdy_rnd = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      wrd_t w;
      if (m_valid0 && m_ready0) begin
         w.d = m_data0; w.k = m_keep0;
         w.l = m_last0; w.len = m_last0 ? m_len0 : 16'h0;
         q0.push_back(w);
      end
      if (m_valid1) begin
         w.d = m_data1; w.k = m_keep1;
         w.l = m_last1; w.len = m_last1 ? m_len1 : 16'h0;
         q1.push_back(w);
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send0(input logic [7:0] d, input logic l,
                        input int gap);
      int n;
      logic ok;
      if (gap > 0) begin
         s_valid0 = 1'b0;
         tick($urandom_range(0, gap));
      end
      s_valid0 = 1'b1; s_data0 = d; s_last0 = l;
      n = 0;
      do begin
         @(negedge clk);
         ok = s_ready0;
         tick(1);
         n++;
      end while (!ok && n < 2000);
      if (!ok) chk("send0_timeout", 32'd0, 32'd1);
   endtask

   task automatic send1(input logic [7:0] d, input logic l);
      int n;
      logic ok;
      s_valid1 = 1'b1; s_data1 = d; s_last1 = l;
      n = 0;
      do begin
         @(negedge clk);
         ok = s_ready1;
         tick(1);
         n++;
      end while (!ok && n < 2000);
      if (!ok) chk("send1_timeout", 32'd0, 32'd1);
   endtask

   task automatic wchk0(input string tag, input int i,
                        input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic [15:0] len);
      if (q0.size() <= i) begin
         chk({tag, "_missing"}, 32'(q0.size()), 32'(i + 1));
      end else begin
         chk({tag, "_data"}, q0[i].d, d);
         chk({tag, "_keep"}, 32'(q0[i].k), 32'(k));
         chk({tag, "_last"}, 32'(q0[i].l), 32'(l));
         if (l) chk({tag, "_len"}, 32'(q0[i].len), 32'(len));
      end
   endtask

   task automatic wchk1(input string tag, input int i,
                        input logic [31:0] d, input logic [3:0] k,
                        input logic [15:0] len);
      if (q1.size() <= i) begin
         chk({tag, "_missing"}, 32'(q1.size()), 32'(i + 1));
      end else begin
         chk({tag, "_data"}, q1[i].d, d);
         chk({tag, "_keep"}, 32'(q1[i].k), 32'(k));
         chk({tag, "_last"}, 32'(q1[i].l), 32'd1);
         chk({tag, "_len"}, 32'(q1[i].len), 32'(len));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(m_valid0), 32'd0);
      chk({tag, "_last"}, 32'(m_last0), 32'd0);
      chk({tag, "_keep"}, 32'(m_keep0), 32'd0);
      chk({tag, "_data"}, m_data0, 32'd0);
      chk({tag, "_len"}, 32'(m_len0), 32'd0);
      chk({tag, "_pkt"}, 32'(pkt0), 32'd0);
      chk({tag, "_sready"}, 32'(s_ready0), 32'd0);
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] hold_d;
      logic [3:0]  hold_k;
      logic [31:0] ew;
      int          nb;

      // reset state
      tick(2);
      @(negedge clk);
      chk_zero("rst");
      chk("rst_sready1", 32'(s_ready1), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      tick(1);

      // 8-byte packet
      for (int i = 1; i <= 8; i++)
         send0(8'(i), i == 8, 0);
      s_valid0 = 1'b0;
      tick(3);
      chk("p8_words", 32'(q0.size()), 32'd2);
      wchk0("p8_w0", 0, 32'h04030201, 4'hF, 1'b0, 16'd0);
      wchk0("p8_w1", 1, 32'h08070605, 4'hF, 1'b1, 16'd8);
      chk("p8_pkt", 32'(pkt0), 32'd1);
      q0.delete();

      // 5-byte packet, zero padding
      send0(8'hAA, 1'b0, 0);
      send0(8'hBB, 1'b0, 0);
      send0(8'hCC, 1'b0, 0);
      send0(8'hDD, 1'b0, 0);
      send0(8'hEE, 1'b1, 0);
      s_valid0 = 1'b0;
      tick(3);
      wchk0("p5_w0", 0, 32'hDDCCBBAA, 4'hF, 1'b0, 16'd0);
      wchk0("p5_w1", 1, 32'h000000EE, 4'h1, 1'b1, 16'd5);
      chk("p5_pkt", 32'(pkt0), 32'd2);
      q0.delete();

      // 0xFF padding: 1-byte then 3-byte packet
      send1(8'h5A, 1'b1);
      send1(8'h11, 1'b0);
      send1(8'h22, 1'b0);
      send1(8'h33, 1'b1);
      s_valid1 = 1'b0;
      tick(3);
      wchk1("pad_w0", 0, 32'hFFFFFF5A, 4'h1, 16'd1);
      wchk1("pad_w1", 1, 32'hFF332211, 4'h7, 16'd3);
      chk("pad_pkt", 32'(pkt1), 32'd2);

      // output stall for 10 cycles
      rdy_man = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++)
               send0(8'h20 + 8'(i), i == 11, 0);
            s_valid0 = 1'b0;
         end
         begin
            nb = 0;
            do begin
               @(negedge clk);
               nb++;
            end while (!m_valid0 && nb < 100);
            chk("stall_seen", 32'(m_valid0), 32'd1);
            hold_d = m_data0;
            hold_k = m_keep0;
            for (int i = 0; i < 10; i++) begin
               tick(1);
               @(negedge clk);
               chk("stall_sready", 32'(s_ready0), 32'd0);
               chk("stall_data", m_data0, hold_d);
               chk("stall_keep", 32'(m_keep0), 32'(hold_k));
            end
            tick(1);
            rdy_man = 1'b1;
         end
      join
      tick(3);
      chk("stall_hold", hold_d, 32'h23222120);
      chk("stall_words", 32'(q0.size()), 32'd3);
      wchk0("stall_w0", 0, 32'h23222120, 4'hF, 1'b0, 16'd0);
      wchk0("stall_w1", 1, 32'h27262524, 4'hF, 1'b0, 16'd0);
      wchk0("stall_w2", 2, 32'h2B2A2928, 4'hF, 1'b1, 16'd12);
      chk("stall_pkt", 32'(pkt0), 32'd3);
      q0.delete();

      // reset mid-packet
      send0(8'h77, 1'b0, 0);
      send0(8'h78, 1'b0, 0);
      s_valid0 = 1'b0;
      rst = 1'b0;
      #1;
      chk_zero("mrst");
      @(posedge clk); #1;
      rst = 1'b1;
      tick(1);
      q0.delete();
      for (int i = 0; i < 4; i++)
         send0(8'h10 + 8'(i), i == 3, 0);
      s_valid0 = 1'b0;
      tick(3);
      chk("mrst_words", 32'(q0.size()), 32'd1);
      wchk0("mrst_w0", 0, 32'h13121110, 4'hF, 1'b1, 16'd4);
      chk("mrst_pkt", 32'(pkt0), 32'd1);
      q0.delete();

      // 23-byte packet with random gaps and random m_ready
      rnd_mode = 1'b1;
      for (int i = 0; i < 23; i++)
         send0(8'(i * 7 + 3), i == 22, 3);
      s_valid0 = 1'b0;
      rnd_mode = 1'b0;
      tick(4);
      chk("gap_words", 32'(q0.size()), 32'd6);
      for (int w = 0; w < 6; w++) begin
         ew = '0;
         for (int j = 0; j < 4; j++) begin
            if (w * 4 + j < 23) begin
               b = 8'((w * 4 + j) * 7 + 3);
               ew = ew | (32'(b) << (8 * j));
            end
         end
         wchk0("gap_w", w, ew, (w == 5) ? 4'h7 : 4'hF,
               w == 5, 16'd23);
      end
      gq = q0;
      q0.delete();
      for (int i = 0; i < 23; i++)
         send0(8'(i * 7 + 3), i == 22, 0);
      s_valid0 = 1'b0;
      tick(3);
      chk("nogap_words", 32'(q0.size()), 32'(gq.size()));
      for (int w = 0; w < 6; w++)
         if (w < gq.size() && w < q0.size())
            chk("nogap_same", q0[w].d, gq[w].d);
      q0.delete();

      // 70000-byte packet: length saturates
      for (int i = 0; i < 70000; i++)
         send0(8'(i), i == 69999, 0);
      s_valid0 = 1'b0;
      tick(3);
      chk("big_words", 32'(q0.size()), 32'd17500);
      if (q0.size() > 0) begin
         chk("big_data", q0[q0.size()-1].d, 32'h6F6E6D6C);
         chk("big_keep", 32'(q0[q0.size()-1].k), 32'hF);
         chk("big_last", 32'(q0[q0.size()-1].l), 32'd1);
         chk("big_len", 32'(q0[q0.size()-1].len), 32'hFFFF);
      end
      chk("big_mlen", 32'(m_len0), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_byte_packer.md
# axis_byte_packer

Downstream AXI-Stream width converter for the 8-bit register stage: accepts the 8-bit byte stream (data/valid/ready/last) and packs it into 32-bit words with per-byte keep and last. A packet shorter than a multiple of four is flushed on its last byte as a partial word. The block also reports per-packet byte length and a running packet count. Its output feeds the 32-bit datapath.

## Interface
- PAD_BYTE, 8'h00, value driven on unfilled byte lanes of a partial word
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release assumed from system
- s_data  in  8  input byte
- s_valid  in  1  input byte valid
- s_ready  out  1  block can accept a byte
- s_last  in  1  byte is last of packet
- m_data  out  32  packed word; first byte of word in [7:0], little-endian
- m_keep  out  4  byte-lane valid mask; bit i covers m_data[8i+7:8i]
- m_valid  out  1  word valid
- m_ready  in  1  downstream accepts word
- m_last  out  1  word contains last byte of packet
- m_len  out  16  byte length of packet; meaningful only when m_valid && m_last
- pkt_count  out  16  number of packets fully delivered (m_last handshakes), wraps at 16'hFFFF -> 0

## Operation
- Byte accepted when s_valid && s_ready. Word delivered when m_valid && m_ready.
- Accumulator holds up to 3 bytes plus lane index idx (0..3). Accepted byte goes to lane idx.
- Commit when accepted byte has idx==3 or s_last==1:
  - Output register loads accumulator bytes plus the current byte.
  - Lanes above the current byte get PAD_BYTE.
  - m_keep = bits 0..idx set (1, 3, 7 or F).
  - m_last = s_last.
  - m_valid = 1.
  - idx returns to 0.
- Otherwise the byte is stored in its lane and idx increments.
- s_ready = rst && (!m_valid || m_ready). The output register is the only buffer; acceptance depends combinationally on m_ready. This allows one byte per cycle sustained.
- Length counter:
  - len_cnt increments per accepted byte and saturates at 16'hFFFF.
  - On commit with s_last, m_len loads the final count, including the current byte, and len_cnt clears to 0.
  - m_len holds between packets.
- pkt_count increments on each handshake with m_last=1.
- Output-register drain and new-commit load in the same cycle are legal: the new word replaces the old one and m_valid stays 1.
- Packet of exactly 4N bytes: the last word has keep F and last 1. No empty trailing word is emitted.
- s_last on lane 0 produces keep 1 and lanes 1..3 = PAD_BYTE.
- Output stall: m_valid && !m_ready forces s_ready=0. Accumulator and output register are frozen.

## Timing
- Reset (rst=0, asynchronous):
  - Outputs: m_valid=0, m_last=0, m_keep=0, m_data=0, m_len=0, pkt_count=0, s_ready=0.
  - Internal: idx=0, len_cnt=0.
- Reset mid-packet discards partial accumulator and output word. The first byte after release is lane 0 of a new packet.
- Latency: m_valid rises on the clock edge that accepts the committing byte. Word is visible the following cycle.
- m_data, m_keep, m_last and m_len are stable while m_valid && !m_ready.
- Throughput: 4-byte words at 1 word per 4 cycles with m_ready held high; 1 byte per cycle in.
- Upstream s_ready duty pattern and gaps in s_valid only delay the packing; they never alter lane order.

## Structure
- Shared package axis_pkg:
  - BYTE_W=8, WORD_BYTES=4, LEN_W=16.
  - keep-mask constants KEEP_1=4'h1, KEEP_2=4'h3, KEEP_3=4'h7, KEEP_4=4'hF.
- Single module. No sub-module needed: the accumulator, output register and counters are compact.

## Test plan
- Reset then 8 bytes 01..08, last on 08, m_ready=1 -> two words: 0x04030201 (keep F, last 0), then 0x08070605 (keep F, last 1), m_len=8, pkt_count=1.
- 5-byte packet AA..EE, PAD_BYTE=00 -> 0xDDCCBBAA keep F, then 0x000000EE keep 1 last 1, m_len=5.
- 1-byte packet 5A with PAD_BYTE=FF -> 0xFFFFFF5A keep 1 last 1, m_len=1. Then 3-byte packet 11 22 33 -> 0xFF332211 keep 7, m_len=3, pkt_count=2.
- Hold m_ready=0 for 10 cycles after the first word commits -> s_ready=0 and outputs stable. Release m_ready -> no byte lost or duplicated across the full packet.
- Pull rst low for one cycle after 2 bytes of a packet -> all outputs zero. Then 4 bytes 10..13 with last -> single word 0x13121110 keep F last 1, m_len=4.
- 70000-byte packet -> m_len=FFFF (saturated). Random valid/ready gaps produce an identical word stream to the gap-free run.
